kgp_alu_seq: RTL

//  Execution-stage ALU of the KGP-RISC datapath; consumer of the 4-bit ALU control code from the ALU control unit.

---
 rtl/kgp_alu_pkg.sv | 25 ++
 rtl/alu_shift_engine.sv | 47 ++++
 rtl/kgp_alu_seq.sv | 108 ++++++++++
 3 files changed

// File: rtl/kgp_alu_pkg.sv
// kgp_alu_pkg: ALU control codes, FSM state encoding and shift-op classifier shared by the KGP-RISC ALU.
package kgp_alu_pkg;
    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_COMP  = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SHLL  = 4'b0101;
    localparam logic [3:0] ALU_SHRL  = 4'b0110;
    localparam logic [3:0] ALU_SHRA  = 4'b0111;
    localparam logic [3:0] ALU_NOP   = 4'b1011;
    localparam logic [3:0] ALU_SHLLV = 4'b1101;
    localparam logic [3:0] ALU_SHRLV = 4'b1110;
    localparam logic [3:0] ALU_SHRAV = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    // Shift codes are x101, x110, x111: bit 2 set plus either low bit set.
    function automatic logic is_shift(input logic [3:0] c);
        return c[2] && (c[1] || c[0]);
    endfunction
endpackage

// File: rtl/alu_shift_engine.sv
// alu_shift_engine: iterative 1-bit-per-cycle shifter.
//   clk/rst  clock, synchronous active-high reset
//   load     capture din, amt, right, arith (amt must be nonzero)
//   step     perform one 1-bit shift of the held value
//   nxt      held value shifted by one more bit (result of the next step)
//   last     the upcoming step is the final one
module alu_shift_engine #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [DATA_W-1:0] din,
    input  logic [SHAMT_W-1:0] amt,
    input  logic              right,
    input  logic              arith,
    output logic [DATA_W-1:0] nxt,
    output logic              last
);
    logic [DATA_W-1:0]  val;
    logic [SHAMT_W-1:0] cnt;
    logic               r;
    logic               ar;

    assign nxt  = r ? {ar & val[DATA_W-1], val[DATA_W-1:1]} : {val[DATA_W-2:0], 1'b0};
    assign last = cnt == '0;

    // Counter runs amt-1 down to 0 so that 'last' marks the amt-th step.
    always_ff @(posedge clk) begin
        if (rst) begin
            val <= '0;
            cnt <= '0;
            r   <= 1'b0;
            ar  <= 1'b0;
        end else if (load) begin
            val <= din;
            cnt <= amt - 1'b1;
            r   <= right;
            ar  <= arith;
        end else if (step) begin
            val <= nxt;
            cnt <= cnt - 1'b1;
        end
    end
endmodule

// File: rtl/kgp_alu_seq.sv
// kgp_alu_seq: execution-stage ALU with start/busy/done handshake and iterative shifter.
//   clk/rst   clock, synchronous active-high reset
//   start     request, accepted only while busy==0
//   alu_ctrl  4-bit operation code; a, b operands (b[SHAMT_W-1:0] is the shift amount)
//   busy      high from the accept edge through the done cycle
//   done      one-cycle pulse; result and flags valid from this cycle and held until next done
//   result, carry, zero, sign, illegal  registered result and flags
module kgp_alu_seq
    import kgp_alu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        alu_ctrl,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero,
    output logic              sign,
    output logic              illegal
);
    state_t             state;
    logic               sh;
    logic               legal;
    logic               accept;
    logic               long_shift;
    logic               go;
    logic [SHAMT_W-1:0] amt;
    logic [DATA_W:0]    op;
    logic [DATA_W-1:0]  fin_res;
    logic               fin_c;
    logic               fin_ill;
    logic [DATA_W-1:0]  eng_nxt;
    logic               eng_last;

    assign sh         = is_shift(alu_ctrl);
    assign amt        = b[SHAMT_W-1:0];
    assign accept     = start && !busy;
    assign long_shift = sh && amt != '0;
    assign legal      = alu_ctrl inside {ALU_ADD, ALU_COMP, ALU_AND, ALU_XOR, ALU_SHLL, ALU_SHRL,
                                         ALU_SHRA, ALU_NOP, ALU_SHLLV, ALU_SHRLV, ALU_SHRAV};

    // Single-cycle ops carry their carry-out in op[DATA_W]; COMP's carry is set only for b==0.
    always_comb begin
        op = alu_ctrl == ALU_ADD  ? {1'b0, a} + {1'b0, b} :
             alu_ctrl == ALU_COMP ? {1'b0, ~b} + 1'b1 :
             alu_ctrl == ALU_AND  ? {1'b0, a & b} :
             alu_ctrl == ALU_XOR  ? {1'b0, a ^ b} : '0;
    end

    // A zero-amount shift completes directly with the unshifted operand.
    always_comb begin
        fin_res = state == S_SHIFT ? eng_nxt : sh ? a : op[DATA_W-1:0];
        fin_c   = state == S_SHIFT ? 1'b0 : op[DATA_W];
        fin_ill = state == S_IDLE && !legal;
    end

    assign go = (accept && !long_shift) || (state == S_SHIFT && eng_last);

    alu_shift_engine #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W)) u_shift (
        .clk   (clk),
        .rst   (rst),
        .load  (accept && long_shift),
        .step  (state == S_SHIFT),
        .din   (a),
        .amt   (amt),
        .right (alu_ctrl[1]),
        .arith (alu_ctrl[1] & alu_ctrl[0]),
        .nxt   (eng_nxt),
        .last  (eng_last)
    );

    // RESP is the done cycle itself; results are registered on the edge that enters it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            carry   <= 1'b0;
            zero    <= 1'b0;
            sign    <= 1'b0;
            illegal <= 1'b0;
        end else if (state == S_RESP) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (go) begin
            state   <= S_RESP;
            busy    <= 1'b1;
            done    <= 1'b1;
            result  <= fin_res;
            carry   <= fin_c;
            zero    <= fin_res == '0;
            sign    <= fin_res[DATA_W-1];
            illegal <= fin_ill;
        end else if (accept) begin
            state <= S_SHIFT;
            busy  <= 1'b1;
        end
    end
endmodule
